// File: rtl/pcie_cfg_mgmt_arbiter_if.sv
// Request/response and cfg_mgmt bus bundle for the config-management arbiter.
// The slave side is the arbiter; the master side is the requesters plus the core.
interface pcie_cfg_mgmt_arbiter_if;
    logic             i_lnk_up;
    logic [1:0]       i_req_valid;
    logic [1:0]       i_req_we;
    logic [1:0][9:0]  i_req_addr;
    logic [1:0][31:0] i_req_wdata;
    logic [1:0][3:0]  i_req_wstrb;
    logic [1:0]       o_req_ready;
    logic [1:0]       o_resp_valid;
    logic [31:0]      o_resp_rdata;
    logic             o_resp_err;
    logic [9:0]       o_cfg_mgmt_dwaddr;
    logic [31:0]      o_cfg_mgmt_di;
    logic [3:0]       o_cfg_mgmt_byte_en;
    logic             o_cfg_mgmt_wr_en;
    logic             o_cfg_mgmt_rd_en;
    logic [31:0]      i_cfg_mgmt_do;
    logic             i_cfg_mgmt_rd_wr_done;

    modport slave (
        input  i_lnk_up,
        input  i_req_valid,
        input  i_req_we,
        input  i_req_addr,
        input  i_req_wdata,
        input  i_req_wstrb,
        output o_req_ready,
        output o_resp_valid,
        output o_resp_rdata,
        output o_resp_err,
        output o_cfg_mgmt_dwaddr,
        output o_cfg_mgmt_di,
        output o_cfg_mgmt_byte_en,
        output o_cfg_mgmt_wr_en,
        output o_cfg_mgmt_rd_en,
        input  i_cfg_mgmt_do,
        input  i_cfg_mgmt_rd_wr_done
    );

    modport master (
        output i_lnk_up,
        output i_req_valid,
        output i_req_we,
        output i_req_addr,
        output i_req_wdata,
        output i_req_wstrb,
        input  o_req_ready,
        input  o_resp_valid,
        input  o_resp_rdata,
        input  o_resp_err,
        input  o_cfg_mgmt_dwaddr,
        input  o_cfg_mgmt_di,
        input  o_cfg_mgmt_byte_en,
        input  o_cfg_mgmt_wr_en,
        input  o_cfg_mgmt_rd_en,
        output i_cfg_mgmt_do,
        output i_cfg_mgmt_rd_wr_done
    );
endinterface

// File: rtl/pcie_cfg_mgmt_arbiter.sv
// Round-robin two-requester arbiter and single-dword sequencer for the
// PCIe cfg_mgmt port, with timeout and link-down abort.
module pcie_cfg_mgmt_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                    i_clk,
    input logic                    i_nrst,
    pcie_cfg_mgmt_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  ben_q, ben_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        grant;
    logic [1:0]  ready;
    logic        accept;

    // Lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant = bus.i_req_valid[1];
        if (&bus.i_req_valid) begin
            grant = ~last_q;
        end
        ready = '0;
        if (state_q == IDLE && i_nrst) begin
            ready[grant] = bus.i_req_valid[grant];
        end
    end

    assign accept = |ready;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ben_d    = ben_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.i_req_we[grant];
                    addr_d  = bus.i_req_addr[grant];
                    wdata_d = bus.i_req_wdata[grant];
                    ben_d   = bus.i_req_we[grant] ? bus.i_req_wstrb[grant] : 4'hF;
                    last_d  = grant;
                    if (bus.i_lnk_up) begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                        wr_en_d = bus.i_req_we[grant];
                        rd_en_d = ~bus.i_req_we[grant];
                    end else begin
                        state_d         = RESP;
                        rvalid_d[grant] = 1'b1;
                        rdata_d         = '0;
                        err_d           = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Completion beats a coincident timeout or link drop.
                if (bus.i_cfg_mgmt_rd_wr_done) begin
                    state_d          = RESP;
                    rvalid_d[last_q] = 1'b1;
                    rdata_d          = we_q ? 32'h0 : bus.i_cfg_mgmt_do;
                    err_d            = 1'b0;
                end else if (cnt_q == LAST_CNT || !bus.i_lnk_up) begin
                    state_d          = RESP;
                    rvalid_d[last_q] = 1'b1;
                    rdata_d          = '0;
                    err_d            = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    wr_en_d = we_q;
                    rd_en_d = ~we_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ben_q    <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ben_q    <= ben_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_req_ready        = ready;
    assign bus.o_resp_valid       = rvalid_q;
    assign bus.o_resp_rdata       = rdata_q;
    assign bus.o_resp_err         = err_q;
    assign bus.o_cfg_mgmt_dwaddr  = addr_q;
    assign bus.o_cfg_mgmt_di      = wdata_q;
    assign bus.o_cfg_mgmt_byte_en = ben_q;
    assign bus.o_cfg_mgmt_wr_en   = wr_en_q;
    assign bus.o_cfg_mgmt_rd_en   = rd_en_q;

endmodule
